booth_seq_multiplier: RTL and testbench

//  Sequential radix-2 Booth multiplier. An FSM and a step counter drive one shared add/sub/shift step

---
 rtl/booth_seq_multiplier_pkg.sv | 20 ++
 rtl/booth_seq_multiplier_if.sv | 30 +++
 rtl/booth_seq_multiplier_step.sv | 36 +++
 rtl/booth_seq_multiplier.sv | 126 ++++++++++++
 tb/tb_booth_seq_multiplier.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared types and Booth decode for booth_seq_multiplier
// Revision  : 1.0
// ============================================================================
package booth_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} booth_state_t;
  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// booth_seq_multiplier_if : operand/result valid-ready bundle
// Revision                : 1.0
// ============================================================================
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 32
);

  logic                   start;
  logic                   ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;

  modport master (
    output start, multiplicand, multiplier, out_ready,
    input  ready, out_valid, result, busy
  );

  modport slave (
    input  start, multiplicand, multiplier, out_ready,
    output ready, out_valid, result, busy
  );

endinterface
`default_nettype wire

// File: rtl/booth_seq_multiplier_step.sv
`default_nettype none
// ============================================================================
// booth_step : one radix-2 Booth add/sub followed by a 1-bit arithmetic shift
// Revision   : 1.0
// ============================================================================
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH:0]   a,
  input  wire logic [WIDTH-1:0] q,
  input  wire logic             q_m1,
  input  wire logic [WIDTH:0]   m,
  output logic      [WIDTH:0]   a_next,
  output logic      [WIDTH-1:0] q_next,
  output logic                  q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case (booth_decode(q[0], q_m1))
      OP_ADD:  sum = a + m;
      OP_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end

  assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// booth_seq_multiplier : sequential radix-2 Booth signed multiplier, WIDTH steps
// Option BOOTH_EARLY_TERM_EN : finish early once all remaining steps are no-ops
// Revision             : 1.0
// ============================================================================
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic              clk,
  input wire logic              rst,
  booth_seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  booth_state_t           state_q, state_d;
  logic [WIDTH:0]         a_q, m_q;
  logic [WIDTH-1:0]       q_q;
  logic                   qm1_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     result_q;

  logic                   ready, busy, out_valid, early;
  logic [WIDTH:0]         step_a, nxt_a;
  logic [WIDTH-1:0]       step_q, nxt_q;
  logic                   step_qm1, nxt_qm1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_q),
    .q         (q_q),
    .q_m1      (qm1_q),
    .m         (m_q),
    .a_next    (step_a),
    .q_next    (step_q),
    .q_m1_next (step_qm1)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // Unprocessed multiplier bits sit in Q[WIDTH-1-count:0]; if they all match q_m1,
  // every remaining step is a pure shift, so collapse them into one wide shift.
  logic [CNT_W:0]             rem;
  logic [WIDTH-1:0]           rem_mask;
  logic signed [2*WIDTH+1:0]  cat_shifted;

  assign rem         = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
  assign rem_mask    = ~({WIDTH{1'b1}} << rem);
  assign early       = ((q_q & rem_mask) == (qm1_q ? rem_mask : '0));
  assign cat_shifted = $signed({a_q, q_q, qm1_q}) >>> rem;
  assign nxt_a       = early ? cat_shifted[2*WIDTH+1:WIDTH+1] : step_a;
  assign nxt_q       = early ? cat_shifted[WIDTH:1]           : step_q;
  assign nxt_qm1     = early ? cat_shifted[0]                 : step_qm1;
`else
  assign early   = 1'b0;
  assign nxt_a   = step_a;
  assign nxt_q   = step_q;
  assign nxt_qm1 = step_qm1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (early || cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q   <= '0;
            q_q   <= bus.multiplier;
            qm1_q <= 1'b0;
            m_q   <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          a_q   <= nxt_a;
          q_q   <= nxt_q;
          qm1_q <= nxt_qm1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (state_d == ST_DONE) result_q <= {nxt_a[WIDTH-1:0], nxt_q};
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// tb_booth_seq_multiplier : directed self-checking bench for booth_seq_multiplier
// Revision                : 1.0
// ============================================================================
module tb_booth_seq_multiplier;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  booth_seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one op, wait for out_valid (bounded), then consume the result.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        output logic [63:0] r, output int lat, output bit to);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = m;
    bus.multiplier = q;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    to = (bus.out_valid !== 1'b1);
    r = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
  endtask

  task automatic test_basic();
    logic [63:0] r; int lat; bit to;
    run_op(32'd7, 32'hFFFF_FFFD, r, lat, to);
    total++; if (to || r !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL basic_7x-3 got=%h want=ffffffffffffffeb", r); end
`ifndef BOOTH_EARLY_TERM_EN
    total++; if (lat != 32) begin bad++; $display("FAIL basic_latency got=%0d want=32", lat); end
`endif
  endtask

  task automatic test_corners();
    logic [63:0] r; int lat; bit to;
    run_op(32'h8000_0000, 32'h8000_0000, r, lat, to);
    total++; if (to || r !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL min_x_min got=%h want=4000000000000000", r); end
    run_op(32'h8000_0000, 32'h1, r, lat, to);
    total++; if (to || r !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL min_x_1 got=%h want=ffffffff80000000", r); end
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, r, lat, to);
    total++; if (to || r !== 64'h3FFF_FFFF_0000_0001) begin bad++; $display("FAIL max_x_max got=%h want=3fffffff00000001", r); end
    run_op(32'hFFFF_FFFF, 32'h8000_0000, r, lat, to);
    total++; if (to || r !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL m1_x_min got=%h want=0000000080000000", r); end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, to);
    total++; if (to || r !== 64'h1) begin bad++; $display("FAIL m1_x_m1 got=%h want=1", r); end
    run_op(32'd123456, -32'sd789, r, lat, to);
    total++; if (to || r !== 64'hFFFF_FFFF_FA31_B0C0) begin bad++; $display("FAIL mixed got=%h want=fffffffffa31b0c0", r); end
  endtask

  task automatic test_ignore_and_hold();
    int waited;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd3; bus.multiplier = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd100; bus.multiplier = 32'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ignore_start_busy got=%b want=1", bus.busy); end
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 100) begin @(posedge clk); #1; waited++; end
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 64'd12) begin bad++; $display("FAIL ignore_start_result got=%h want=c", bus.result); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd12) begin
        bad++; $display("FAIL hold_stable cycle=%0d valid=%b got=%h want=c", i, bus.out_valid, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL release_idle ready=%b valid=%b want 1/0", bus.ready, bus.out_valid); end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] r; int lat; bit to;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd11; bus.multiplier = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrun_reset ready=%b busy=%b want 1/0", bus.ready, bus.busy); end
    total++; if (bus.out_valid !== 1'b0 || bus.result !== 64'h0) begin bad++; $display("FAIL midrun_reset valid=%b result=%h want 0/0", bus.out_valid, bus.result); end
    @(negedge clk);
    rst = 1'b1;
    run_op(-32'sd5, 32'd6, r, lat, to);
    total++; if (to || r !== 64'hFFFF_FFFF_FFFF_FFE2) begin bad++; $display("FAIL after_reset got=%h want=ffffffffffffffe2", r); end
  endtask

`ifdef BOOTH_EARLY_TERM_EN
  task automatic test_early_term();
    logic [63:0] r; int lat; bit to;
    run_op(32'd5, 32'd3, r, lat, to);
    total++; if (to || r !== 64'd15) begin bad++; $display("FAIL early_5x3 got=%h want=f", r); end
    total++; if (lat != 4) begin bad++; $display("FAIL early_5x3_latency got=%0d want=4", lat); end
    run_op(32'd9, 32'd0, r, lat, to);
    total++; if (to || r !== 64'd0) begin bad++; $display("FAIL early_9x0 got=%h want=0", r); end
    total++; if (lat != 1) begin bad++; $display("FAIL early_9x0_latency got=%0d want=1", lat); end
  endtask
`endif

  task automatic test_random();
    logic [63:0] r, exp; int lat; bit to;
    logic [31:0] m, q;
    longint mm, qq;
    for (int i = 0; i < 200; i++) begin
      m = $urandom;
      q = $urandom;
      if (i % 4 == 1) q = q >>> (i % 31);
      mm = longint'($signed(m));
      qq = longint'($signed(q));
      exp = 64'(mm * qq);
      run_op(m, q, r, lat, to);
      total++;
      if (to || r !== exp) begin bad++; $display("FAIL random m=%h q=%h got=%h want=%h", m, q, r, exp); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_and_hold();
    test_reset_midrun();
`ifdef BOOTH_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
